// File: rtl/uart_imem_loader_if.sv
// Byte-stream input and imem write bus of uart_imem_loader.
// master: the loader (consumes bytes, drives imem); slave: the surrounding system.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data, rx_break,
    output imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data, rx_break,
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes LSB-first into 32-bit words, writes them to imem from address 0
// until END_WORD, then releases the core. Optional XOR checksum output under LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF,
  parameter int          BYTE_TIMEOUT = 2000000
) (
  input  logic               clk,
  input  logic               resetn,
  uart_imem_loader_if.master bus,
  output logic               write_done,
  output logic               cpu_resetn,
  output logic               load_err,
  output logic [ADDR_W:0]    word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int              TO_W    = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BYTE_TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        byte_idx;
  logic [31:0]       shift;
  logic [31:0]       assembled;
  logic [TO_W-1:0]   idle_cnt;
  logic [ADDR_W-1:0] ptr;
  logic              accept, complete, full, end_seen;

  // The word as it will look once the byte on rx_data lands in the top lane.
  always_comb begin
    assembled        = shift;
    assembled[31:24] = bus.rx_data;
  end

  assign accept   = (state != DONE) && bus.rx_valid && !bus.rx_break;
  assign complete = accept && (byte_idx == 2'd3);
  assign end_seen = (assembled == END_WORD);
  assign full     = (word_count == DEPTH);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= COLLECT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: begin
        if (complete) begin
          if (end_seen)   state_next = DONE;
          else if (!full) state_next = WRITE;
        end
      end
      WRITE:   state_next = COLLECT;
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    bus.imem_we = 1'b0;
    write_done  = 1'b0;
    cpu_resetn  = 1'b0;
    case (state)
      WRITE: bus.imem_we = 1'b1;
      DONE: begin
        write_done = 1'b1;
        cpu_resetn = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte collection stays live in WRITE so a byte arriving there starts the next word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_idx       <= 2'd0;
      shift          <= 32'd0;
      idle_cnt       <= '0;
      ptr            <= '0;
      word_count     <= '0;
      load_err       <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      if (state != DONE) begin
        if (bus.rx_break) begin
          if (byte_idx != 2'd0) load_err <= 1'b1;
          byte_idx <= 2'd0;
          idle_cnt <= '0;
        end else if (bus.rx_valid) begin
          shift[8*byte_idx +: 8] <= bus.rx_data;
          byte_idx               <= byte_idx + 2'd1;
          idle_cnt               <= '0;
        end else if (byte_idx != 2'd0) begin
          if (idle_cnt == TO_LAST) begin
            byte_idx <= 2'd0;
            idle_cnt <= '0;
            load_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end else begin
          idle_cnt <= '0;
        end
      end

      if (complete && !end_seen) begin
        if (full) begin
          load_err <= 1'b1;
        end else begin
          bus.imem_wdata <= assembled;
          bus.imem_addr  <= ptr;
        end
      end

      if (state == WRITE) begin
        ptr <= ptr + ADDR_W'(1);
        if (!full) word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              checksum <= 32'd0;
    else if (state == WRITE)  checksum <= checksum ^ bus.imem_wdata;
  end
`endif

endmodule
